// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage branch resolution for the pipelined OTTER core. Decodes the
// branch funct3 together with the comparator flags, computes the real next
// PC for conditional branches, JAL and JALR, and compares it with what the
// fetch stage predicted. A mispredict produces a registered one-cycle
// redirect and holds the front-end flush for FLUSH_CYCLES cycles in total.
// Saturating counters track resolved control transfers and mispredicts.
//
// Parameters
//   FLUSH_CYCLES  cycles flush is held per mispredict, redirect cycle
//                 included (1..15)
//   CNT_W         width of the performance counters
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid                execute-stage instruction valid
//   ex_is_branch/jal/jalr   instruction class (priority jalr > jal > branch)
//   ex_funct3               branch condition select
//   br_eq, br_lt, br_ltu    comparator flags for rs1 vs rs2
//   ex_pc, ex_imm, ex_rs1   operands for the target computation
//   ex_pred_taken/target    fetch-stage prediction
//   redirect_valid          one-cycle pulse, fetch loads redirect_pc
//   redirect_pc             corrected next PC (valid with redirect_valid)
//   flush                   squash IF/ID and invalidate EX
//   illegal_br              one-cycle pulse for branch funct3 010/011
//   br_cnt, misp_cnt        saturating performance counters
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jal,
    input  logic             ex_is_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_imm,
    input  logic [31:0]      ex_rs1,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] misp_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDIRECT,
        ST_FLUSH
    } state_t;

    // The redirect cycle is the first flush cycle, and the flush state runs
    // one cycle longer than its reload value, hence the minus two.
    localparam logic [3:0] FLUSH_RELOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t      state;
    state_t      next_state;
    logic [3:0]  flush_left;
    logic [3:0]  next_flush_left;

    logic        accept;
    logic        sel_jalr;
    logic        sel_jal;
    logic        branch_taken;
    logic        bad_funct3;
    logic        taken;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        mispredict;

    // Branch condition decode; funct3 010/011 are not branches and resolve
    // as not taken.
    always_comb begin
        branch_taken = 1'b0;
        bad_funct3   = 1'b0;
        case (ex_funct3)
            3'b000:  branch_taken = br_eq;
            3'b001:  branch_taken = !br_eq;
            3'b100:  branch_taken = br_lt;
            3'b101:  branch_taken = !br_lt;
            3'b110:  branch_taken = br_ltu;
            3'b111:  branch_taken = !br_ltu;
            default: bad_funct3   = 1'b1;
        endcase
    end

    // Resolution of the instruction in EX: only accepted while idle, since
    // anything arriving during a redirect/flush is on the wrong path.
    always_comb begin
        accept   = ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr) && (state == ST_IDLE);
        sel_jalr = ex_is_jalr;
        sel_jal  = ex_is_jal && !ex_is_jalr;
        taken    = (sel_jalr || sel_jal) ? 1'b1 : branch_taken;
        if (sel_jalr) begin
            target = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
        end else begin
            target = ex_pc + ex_imm;
        end
        next_pc    = taken ? target : (ex_pc + 32'd4);
        mispredict = (taken != ex_pred_taken) || (taken && (ex_pred_target != target));
    end

    // State register and flush down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            flush_left <= 4'd0;
        end else begin
            state      <= next_state;
            flush_left <= next_flush_left;
        end
    end

    // Next-state logic: a mispredict opens a redirect cycle, followed by
    // the remaining flush cycles counted down in flush_left.
    always_comb begin
        next_state      = state;
        next_flush_left = flush_left;
        case (state)
            ST_IDLE: begin
                if (accept && mispredict) begin
                    next_state = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    next_state      = ST_FLUSH;
                    next_flush_left = FLUSH_RELOAD;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_left == 4'd0) begin
                    next_state = ST_IDLE;
                end else begin
                    next_flush_left = flush_left - 4'd1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign redirect_valid = (state == ST_REDIRECT);
    assign flush          = (state != ST_IDLE);

    // Captured redirect target, illegal-funct3 pulse and saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc <= 32'd0;
            illegal_br  <= 1'b0;
            br_cnt      <= '0;
            misp_cnt    <= '0;
        end else begin
            illegal_br <= accept && !sel_jalr && !sel_jal && bad_funct3;
            if (accept && mispredict) begin
                redirect_pc <= next_pc;
            end
            if (accept && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (accept && mispredict && (misp_cnt != '1)) begin
                misp_cnt <= misp_cnt + CNT_W'(1);
            end
        end
    end

endmodule
